mux_read_arbiter: RTL



---
 rtl/mux_read_arbiter_pkg.sv | 20 ++
 rtl/mux_read_arbiter_rr_priority_pick.sv | 39 +++
 rtl/mux_read_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mux_read_arbiter_pkg.sv
// Shared definitions for the register-file read-path arbiter.
// State encodings, default sizes and a pointer-width helper.
// Optional feature macro used by the arbiter: MUX_ARB_LOCK_EN.
package mux_read_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_READ = 1'b1
  } arb_state_e;

  localparam int ARB_NUM_REQ_DEF    = 4;
  localparam int ARB_SEL_WIDTH_DEF  = 5;
  localparam int ARB_DATA_WIDTH_DEF = 32;

  // Width of a requester index; at least one bit even for tiny configs.
  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_read_arbiter_rr_priority_pick.sv
// Round-robin priority pick: first eligible requester after ptr, wrapping.
// Purely combinational, zero latency.
// No flow control; the caller decides when the pick is used.
module rr_priority_pick
  import mux_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ_DEF,
  parameter int PW      = ptr_width(ARB_NUM_REQ_DEF)
) (
  input  logic [NUM_REQ-1:0] elig_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] win_o,
  output logic [PW-1:0]      win_idx_o,
  output logic               win_any_o
);

  // Scan from ptr+1 around to ptr itself; the first set bit wins.
  always_comb begin
    logic [PW-1:0] cand;
    logic          found;
    int            j;
    win_o     = '0;
    win_idx_o = '0;
    found     = 1'b0;
    cand      = '0;
    j         = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      j    = (int'(ptr_i) + off) % NUM_REQ;
      cand = PW'(j);
      if (!found && elig_i[cand]) begin
        found       = 1'b1;
        win_o[cand] = 1'b1;
        win_idx_o   = cand;
      end
    end
    win_any_o = found;
  end

endmodule

// File: rtl/mux_read_arbiter.sv
// Round-robin arbiter for one shared 32:1 read mux; optional grant lock under MUX_ARB_LOCK_EN.
// Latency: REQ sampled at edge k -> GNT/MUX_SEL after k -> RDATA/RVALID after k+1.
// Back-to-back reads at one per cycle; losers simply keep REQ high until served.
module mux_read_arbiter
  import mux_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = ARB_NUM_REQ_DEF,
  parameter int SEL_WIDTH  = ARB_SEL_WIDTH_DEF,
  parameter int DATA_WIDTH = ARB_DATA_WIDTH_DEF
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_REQ-1:0]           REQ,
  input  logic [NUM_REQ*SEL_WIDTH-1:0] ADDR,
`ifdef MUX_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]           LOCK,
`endif
  output logic [SEL_WIDTH-1:0]         MUX_SEL,
  input  logic [DATA_WIDTH-1:0]        MUX_DATA,
  output logic [NUM_REQ-1:0]           GNT,
  output logic [DATA_WIDTH-1:0]        RDATA,
  output logic [NUM_REQ-1:0]           RVALID,
  output logic                         BUSY
);

  localparam int PW = ptr_width(NUM_REQ);

  arb_state_e            state_q, state_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [NUM_REQ-1:0]    rvalid_q, rvalid_d;

  logic [SEL_WIDTH-1:0]  addr_a [NUM_REQ];
  logic [NUM_REQ-1:0]    elig;
  logic [NUM_REQ-1:0]    win_oh;
  logic [PW-1:0]         win_idx;
  logic                  win_any;
  logic                  lock_hold;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
    assign addr_a[i] = ADDR[i*SEL_WIDTH +: SEL_WIDTH];
  end

  // The current winner and the one whose data is returning are not eligible again.
  assign elig = REQ & ~gnt_q & ~rvalid_q;

`ifdef MUX_ARB_LOCK_EN
  assign lock_hold = |(REQ & LOCK & gnt_q);
`else
  assign lock_hold = 1'b0;
`endif

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_pick (
    .elig_i    (elig),
    .ptr_i     (ptr_q),
    .win_o     (win_oh),
    .win_idx_o (win_idx),
    .win_any_o (win_any)
  );

  // Next state: capture returning data, then grant the next winner or go idle.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    rdata_d  = rdata_q;
    rvalid_d = '0;
    case (state_q)
      ARB_IDLE: begin
        if (win_any) begin
          gnt_d   = win_oh;
          sel_d   = addr_a[win_idx];
          ptr_d   = win_idx;
          state_d = ARB_READ;
        end
      end
      ARB_READ: begin
        rdata_d  = MUX_DATA;
        rvalid_d = gnt_q;
        if (lock_hold) begin
          // ptr_q still names the locked winner; reload its address only.
          sel_d = addr_a[ptr_q];
        end else if (win_any) begin
          gnt_d = win_oh;
          sel_d = addr_a[win_idx];
          ptr_d = win_idx;
        end else begin
          gnt_d   = '0;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State registers; reset drops any read in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ARB_IDLE;
      gnt_q    <= '0;
      sel_q    <= '0;
      ptr_q    <= PW'(NUM_REQ - 1);
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign MUX_SEL = sel_q;
  assign GNT     = gnt_q;
  assign RDATA   = rdata_q;
  assign RVALID  = rvalid_q;
  assign BUSY    = (state_q == ARB_READ);

endmodule
